zl_ts_sync_aligner: RTL and testbench

- Sits directly upstream of the single-clock packet FIFO in the transport-stream input path.
- Hunts a raw MPEG-TS byte stream for the sync byte and locks onto packet boundaries after consecutive confirmed syncs.
- Once locked, forwards whole packets with a start-of-packet flag into the FIFO write port using req/ack handshaking.
- Drops lock after consecutive sync misses; only complete packets are ever forwarded.

---
 rtl/zl_ts_pkg.sv | 22 ++
 rtl/zl_pipe_stage.sv | 34 +++
 rtl/zl_ts_sync_aligner.sv | 139 +++++++++++++
 tb/tb_zl_ts_sync_aligner.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zl_ts_pkg.sv
// Shared constants, state encoding and width helper for the TS sync aligner.
// Pure declarations: no logic, no latency, no flow control.
package zl_ts_pkg;

  localparam logic [7:0] TS_SYNC_BYTE    = 8'h47;
  localparam int         TS_PKT_LEN      = 188;
  localparam int         TS_LOCK_COUNT   = 3;
  localparam int         TS_UNLOCK_COUNT = 3;
  localparam int         POS_W           = $clog2(TS_PKT_LEN);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } ts_state_e;

  // Bits needed to hold a counter that saturates at n (n >= 1).
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/zl_pipe_stage.sv
// 1-entry registered req/ack stage (data + sop): 1-cycle load-to-req latency.
// Holds its contents until out_ack; can_load allows load and drain in the same cycle.
module zl_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_sop,
  output logic         can_load,
  output logic         out_req,
  input  logic         out_ack,
  output logic [W-1:0] out_data,
  output logic         out_sop
);

  assign can_load = !out_req || out_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_req  <= 1'b0;
      out_data <= '0;
      out_sop  <= 1'b0;
    end else if (load) begin
      out_req  <= 1'b1;
      out_data <= load_data;
      out_sop  <= load_sop;
    end else if (out_ack) begin
      out_req  <= 1'b0;
    end
  end

endmodule

// File: rtl/zl_ts_sync_aligner.sv
// Hunts MPEG-TS sync, locks after repeated syncs, forwards whole packets with sop.
// 1-cycle latency to out_req; in_ack stalls only while locked and the output is blocked.
module zl_ts_sync_aligner
  import zl_ts_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = TS_SYNC_BYTE,
  parameter int         PKT_LEN      = TS_PKT_LEN,
  parameter int         LOCK_COUNT   = TS_LOCK_COUNT,
  parameter int         UNLOCK_COUNT = TS_UNLOCK_COUNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_req,
  output logic       in_ack,
  input  logic [7:0] in_data,
  output logic       out_req,
  input  logic       out_ack,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       locked,
  output logic       sync_miss
);

  localparam int PW = $clog2(PKT_LEN);
  localparam int GW = cnt_w(LOCK_COUNT);
  localparam int MW = cnt_w(UNLOCK_COUNT);
  localparam logic [PW-1:0] POS_LAST  = PW'(PKT_LEN - 1);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_COUNT);
  localparam logic [MW-1:0] MISS_DROP = MW'(UNLOCK_COUNT);

  ts_state_e     state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [GW-1:0] good_q, good_d;
  logic [MW-1:0] miss_q, miss_d;
  logic          load, load_sop, can_load, consume, is_sync, at_pos0, sync_miss_d;

  assign in_ack  = (state_q == LOCK) ? (in_req && can_load) : in_req;
  assign consume = in_req && in_ack;
  assign is_sync = (in_data == SYNC_BYTE);
  assign at_pos0 = (pos_q == '0);

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    good_d      = good_q;
    miss_d      = miss_q;
    load        = 1'b0;
    load_sop    = 1'b0;
    sync_miss_d = 1'b0;
    if (consume) begin
      pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
      unique case (state_q)
        HUNT: begin
          if (is_sync) begin
            good_d = GW'(1);
            pos_d  = PW'(1);
            if (GOOD_LOCK == GW'(1)) begin
              state_d  = LOCK;
              miss_d   = '0;
              load     = 1'b1;
              load_sop = 1'b1;
            end else begin
              state_d = VERIFY;
            end
          end else begin
            pos_d = '0;
          end
        end
        VERIFY: begin
          if (at_pos0) begin
            if (is_sync) begin
              good_d = good_q + GW'(1);
              if (good_d == GOOD_LOCK) begin
                state_d  = LOCK;
                miss_d   = '0;
                load     = 1'b1;
                load_sop = 1'b1;
              end
            end else begin
              // The failing byte is discarded, not rescanned as a new candidate.
              state_d = HUNT;
              pos_d   = '0;
            end
          end
        end
        LOCK: begin
          if (at_pos0 && !is_sync) begin
            miss_d      = miss_q + MW'(1);
            sync_miss_d = 1'b1;
            if (miss_d == MISS_DROP) begin
              state_d = HUNT;
              pos_d   = '0;
            end else begin
              load     = 1'b1;
              load_sop = 1'b1;
            end
          end else begin
            if (at_pos0) miss_d = '0;
            load     = 1'b1;
            load_sop = at_pos0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      pos_q     <= '0;
      good_q    <= '0;
      miss_q    <= '0;
      locked    <= 1'b0;
      sync_miss <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      locked    <= (state_d == LOCK);
      sync_miss <= sync_miss_d;
    end
  end

  zl_pipe_stage #(.W(8)) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (in_data),
    .load_sop  (load_sop),
    .can_load  (can_load),
    .out_req   (out_req),
    .out_ack   (out_ack),
    .out_data  (out_data),
    .out_sop   (out_sop)
  );

endmodule

// File: tb/tb_zl_ts_sync_aligner.sv
// Directed scenarios for zl_ts_sync_aligner checked against a stream-level model.
module tb_zl_ts_sync_aligner;
  import zl_ts_pkg::*;

  localparam int L = TS_PKT_LEN;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_req = 1'b0;
  logic       in_ack;
  logic [7:0] in_data = 8'h00;
  logic       out_req;
  logic       out_ack = 1'b1;
  logic [7:0] out_data;
  logic       out_sop;
  logic       locked;
  logic       sync_miss;

  always #5 clk = ~clk;

  zl_ts_sync_aligner dut (
    .clk       (clk),
    .rst       (rst),
    .in_req    (in_req),
    .in_ack    (in_ack),
    .in_data   (in_data),
    .out_req   (out_req),
    .out_ack   (out_ack),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .locked    (locked),
    .sync_miss (sync_miss)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stimulus stream and model results
  logic [7:0] stream[$];
  logic [8:0] exp_out[$];
  bit         lock_after[$];
  bit         pulse_after[$];
  int m_out_cnt, m_sop_cnt, m_pulses, m_first_lock;
  int junk_k = 0;

  task automatic push_junk(input int n);
    for (int i = 0; i < n; i++) begin
      stream.push_back(8'h10 + 8'(junk_k % 32));
      junk_k++;
    end
  endtask

  task automatic push_pkt(input int p, input logic [7:0] sync);
    stream.push_back(sync);
    for (int j = 1; j < L; j++) stream.push_back(8'h80 | 8'((j + p) & 63));
  endtask

  function automatic void emit(input bit sop, input logic [7:0] b);
    exp_out.push_back({sop, b});
    m_out_cnt++;
    if (sop) m_sop_cnt++;
  endfunction

  // Packet phase is measured from the anchor sync by index arithmetic.
  function automatic void run_model();
    int mode = 0;   // 0 hunting, 1 verifying, 2 locked
    int anchor = 0;
    int good = 0;
    int miss = 0;
    bit pulse;
    int pos;
    logic [7:0] b;
    exp_out.delete();
    lock_after.delete();
    pulse_after.delete();
    m_out_cnt = 0; m_sop_cnt = 0; m_pulses = 0; m_first_lock = -1;
    for (int k = 0; k < stream.size(); k++) begin
      b = stream[k];
      pulse = 1'b0;
      pos = (k - anchor) % L;
      if (mode == 0) begin
        if (b == TS_SYNC_BYTE) begin
          anchor = k;
          good = 1;
          if (TS_LOCK_COUNT == 1) begin mode = 2; miss = 0; emit(1'b1, b); end
          else mode = 1;
        end
      end else if (mode == 1) begin
        if (pos == 0) begin
          if (b == TS_SYNC_BYTE) begin
            good++;
            if (good == TS_LOCK_COUNT) begin mode = 2; miss = 0; emit(1'b1, b); end
          end else mode = 0;
        end
      end else begin
        if (pos != 0) emit(1'b0, b);
        else if (b == TS_SYNC_BYTE) begin miss = 0; emit(1'b1, b); end
        else begin
          miss++;
          pulse = 1'b1;
          m_pulses++;
          if (miss == TS_UNLOCK_COUNT) mode = 0;
          else emit(1'b1, b);
        end
      end
      lock_after.push_back(mode == 2);
      pulse_after.push_back(pulse);
      if (mode == 2 && m_first_lock < 0) m_first_lock = k;
    end
  endfunction

  // Compare process state
  bit         active = 1'b0;
  int         cidx;
  bit         exp_locked, exp_pulse;
  bit         prev_req, prev_ack, prev_sop;
  logic [7:0] prev_data;
  int         stalls;

  always @(negedge clk) begin
    if (!rst && active) begin
      check("locked", locked, exp_locked);
      check("sync_miss", sync_miss, exp_pulse);
      check("in_ack", in_ack, in_req && (!exp_locked || !out_req || out_ack));
      if (prev_req && !prev_ack) begin
        check("hold_req", out_req, 1);
        check("hold_data", out_data, prev_data);
        check("hold_sop", out_sop, prev_sop);
      end
      if (out_req && out_ack) begin
        if (exp_out.size() == 0) check("out_unexpected", exp_out.size(), 1);
        else begin
          check("out_data", out_data, exp_out[0][7:0]);
          check("out_sop", out_sop, exp_out[0][8]);
          void'(exp_out.pop_front());
        end
      end
      if (in_req && !in_ack) stalls++;
      if (in_req && in_ack && cidx < stream.size()) begin
        exp_locked = lock_after[cidx];
        exp_pulse  = pulse_after[cidx];
        cidx++;
      end else begin
        exp_pulse = 1'b0;
      end
      prev_req  = out_req;
      prev_ack  = out_ack;
      prev_data = out_data;
      prev_sop  = out_sop;
    end
  end

  task automatic reset_dut();
    active = 1'b0;
    rst = 1'b1;
    in_req = 1'b0;
    out_ack = 1'b1;
    stream.delete();
    exp_out.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_req", out_req, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sop", out_sop, 0);
    check("rst_locked", locked, 0);
    check("rst_sync_miss", sync_miss, 0);
  endtask

  task automatic arm();
    cidx = 0; exp_locked = 1'b0; exp_pulse = 1'b0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_sop = 1'b0; prev_data = 8'h00;
    stalls = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    active = 1'b1;
  endtask

  task automatic drive(input int stall_at, input int abort_at);
    int i = 0;
    int wait_cnt = 0;
    int stall_left = 0;
    bit took;
    while (i < stream.size()) begin
      if (i == abort_at) begin
        check("pre_rst_out_req", out_req, 1);
        check("pre_rst_locked", locked, 1);
        #2 rst = 1'b1;
        active = 1'b0;
        #1;
        check("async_rst_out_req", out_req, 0);
        check("async_rst_out_sop", out_sop, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_locked", locked, 0);
        in_req = 1'b0;
        return;
      end
      if (i == stall_at && wait_cnt == 0) stall_left = 10;
      out_ack = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      in_req = 1'b1;
      in_data = stream[i];
      @(negedge clk);
      took = in_ack;
      @(posedge clk); #1;
      if (took) begin
        i++;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
        if (wait_cnt > 50) begin
          check("in_ack_timeout", wait_cnt, 0);
          i = stream.size();
        end
      end
    end
    in_req = 1'b0;
    out_ack = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("drained_all", exp_out.size(), 0);
    check("idle_out_req", out_req, 0);
    check("consumed_all", cidx, stream.size());
  endtask

  task automatic scenario_lock();
    reset_dut();
    push_junk(37);
    for (int p = 1; p <= 4; p++) push_pkt(p, TS_SYNC_BYTE);
    run_model();
    check("s1_model_bytes", m_out_cnt, 376);
    check("s1_model_sops", m_sop_cnt, 2);
    check("s1_model_lock_idx", m_first_lock, 413);
    arm();
    drive(-1, -1);
  endtask

  initial begin
    // 1: acquisition
    scenario_lock();

    // 2: false sync then a real train
    reset_dut();
    push_junk(200);
    stream[5] = TS_SYNC_BYTE;
    stream[193] = 8'h12;
    for (int p = 1; p <= 4; p++) push_pkt(p, TS_SYNC_BYTE);
    run_model();
    check("s2_model_bytes", m_out_cnt, 376);
    check("s2_model_lock_idx", m_first_lock, 576);
    arm();
    drive(-1, -1);

    // 3: backpressure mid-packet while locked
    reset_dut();
    for (int p = 1; p <= 6; p++) push_pkt(p, TS_SYNC_BYTE);
    run_model();
    check("s3_model_bytes", m_out_cnt, 752);
    arm();
    drive(3 * L + 50, -1);
    check("s3_stall_cycles", stalls, 10);

    // 4: two misses tolerated twice, miss count cleared by a good sync
    reset_dut();
    for (int p = 1; p <= 11; p++)
      push_pkt(p, (p == 5 || p == 6 || p == 9 || p == 10) ? 8'h00 : TS_SYNC_BYTE);
    run_model();
    check("s4_model_bytes", m_out_cnt, 9 * L);
    check("s4_model_sops", m_sop_cnt, 9);
    check("s4_model_pulses", m_pulses, 4);
    arm();
    drive(-1, -1);
    check("s4_still_locked", locked, 1);

    // 5: lock loss on the third consecutive miss
    reset_dut();
    for (int p = 1; p <= 7; p++) push_pkt(p, (p >= 5) ? 8'h00 : TS_SYNC_BYTE);
    run_model();
    check("s5_model_bytes", m_out_cnt, 4 * L);
    check("s5_model_pulses", m_pulses, 3);
    arm();
    drive(-1, -1);
    check("s5_unlocked", locked, 0);

    // 6: reset at packet position 90 while locked, then reacquire
    reset_dut();
    for (int p = 1; p <= 4; p++) push_pkt(p, TS_SYNC_BYTE);
    run_model();
    arm();
    drive(-1, 3 * L + 90);
    scenario_lock();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
